k12a_alu_sequencer: RTL and testbench
=====================================

Name: k12a_alu_sequencer

Overview:
Control FSM that sequences the shared 8-bit ALU for one requester, the instruction decode stage.
- Accepts one ALU request at a time and arbitrates for the shared data bus.
- Drives the ALU's load, operand-select, subtract and instruction-field inputs, and strobes register A load.
- Supports three request kinds: single-pass result write, condition test (no bus use), and multi-pass arithmetic shift right by N (1–7), which reuses ALU function 6 once per pass.

Parameters:
MAX_SHIFT, 7, largest legal shift count; sets the pass-counter width to 3 bits. No other value is supported.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; accept = req_valid & req_ready at a rising edge
req_kind  input  2  alu_req_kind_t: WRITE=0, TEST=1, SHIFT=2, 3 reserved
req_inst  input  16  instruction word; [10:8] selects ALU function/condition; [7:0] immediate
req_use_b  input  1  1 = operand B, 0 = immediate
req_count  input  3  SHIFT pass count
bus_req  output  1  data-bus request
bus_gnt  input  1  data-bus grant
alu_load_n  output  1  active-low ALU drive onto data bus
alu_operand_sel  output  alu_operand_sel_t  operand select for ALU
alu_subtract  output  1  ALU subtract control
alu_inst  output  16  instruction presented to ALU
alu_condition  input  1  ALU condition result
a_load_n  output  1  active-low register A load from data bus
resp_valid  output  1  one-cycle completion pulse
resp_cond  output  1  TEST result; 0 for WRITE/SHIFT
busy  output  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain (clock). Reset is asynchronous and active-low on reset_n; the polarity and synchronicity are fixed.
- States: IDLE, BUS_WAIT, EXEC, EVAL, RESP.
- Reset values: state IDLE, alu_load_n=1, a_load_n=1, bus_req=0, resp_valid=0, resp_cond=0, alu_subtract=0, alu_operand_sel=ALU_OPERAND_SEL_B, alu_inst=0, pass counter=0.
- Reset mid-operation: outputs return to reset values immediately and asynchronously, including release of the bus with no completion pulse.
- Register outputs: alu_load_n, a_load_n, bus_req and resp_valid are driven directly from flops (glitch-free tri-state control).
- Accept: on accept, latch kind, inst, use_b and count.
  - alu_operand_sel = use_b ? ALU_OPERAND_SEL_B : ALU_OPERAND_SEL_INST.
  - alu_inst = req_inst, except SHIFT forces [10:8]=3'h6.
  - alu_subtract: WRITE → (inst[10:8]==3'h5); TEST → 1; SHIFT → 0.
  - These stay stable until return to IDLE.
- Transitions from IDLE on accept:
  - WRITE → BUS_WAIT.
  - SHIFT with count≠0 → BUS_WAIT.
  - SHIFT with count==0 → RESP (no bus activity).
  - TEST → EVAL.
  - Reserved kind → RESP with resp_cond=0 and no side effects.
- BUS_WAIT: bus_req=1. Leave for EXEC at the first edge sampling bus_gnt=1; wait indefinitely otherwise.
- EXEC:
  - bus_req=1, alu_load_n=0, a_load_n=0 for exactly one cycle per pass.
  - WRITE: one pass, then RESP.
  - SHIFT: count passes back-to-back, counter decrementing each pass; → RESP when the counter reaches 1 at an edge.
  - bus_gnt is required high throughout EXEC; a drop is a protocol violation flagged by a bench assertion. The FSM does not pause.
  - bus_req deasserts on entry to RESP.
- EVAL: one cycle, no bus. alu_condition is sampled into resp_cond at the EVAL→RESP edge.
- RESP: resp_valid=1 for one cycle → IDLE.
  - req_ready is low in RESP, so minimum request spacing is: TEST 3 cycles, WRITE 4 cycles with immediate grant.
- Latency from accept edge to resp_valid cycle: TEST 2 cycles; WRITE 3+wait cycles; SHIFT 2+N+wait cycles; SHIFT N=0 is 1 cycle.

Decomposition:
- Shared package k12a.inc.sv gains:
  - alu_req_kind_t (WRITE/TEST/SHIFT/RSVD);
  - ALU_FUNC_SUB=3'h5 and ALU_FUNC_SAR=3'h6.
- Reuse the existing alu_operand_sel_t.
- No sub-module: a single FSM with a 3-bit down-counter.

Test Plan:
- Reset mid-SHIFT (count=5, during the 3rd EXEC) → within the same cycle alu_load_n=1, a_load_n=1, bus_req=0; no resp_valid; req_ready=1 after release.
- WRITE inst=16'h0512, use_b=0, bus_gnt tied 1 → alu_subtract=1, alu_inst[7:0]=8'h12, sel=INST; exactly one cycle of alu_load_n=a_load_n=0; resp_valid 3 cycles after accept; resp_cond=0.
- TEST inst[10:8]=3'h4, use_b=1, alu_condition driven 1 in EVAL → alu_subtract=1, bus_req never high, resp_cond=1 two cycles after accept.
- SHIFT count=3, bus_gnt delayed 4 cycles → bus_req high 4 cycles before EXEC; alu_inst[10:8]=3'h6; exactly 3 consecutive a_load_n low cycles; resp_valid at accept+9.
- SHIFT count=0 → no bus_req, no load strobes, resp_valid 1 cycle after accept.
- Back-to-back TEST requests with req_valid held high → accepts every 3rd cycle; req_ready low in EVAL and RESP; resp_valid pulses single-cycle each.

Source files
------------

// File: rtl/k12a_alu_sequencer_pkg.sv
// Shared types for the k12a ALU sequencer: request kinds, operand select,
// ALU function codes and FSM state encoding.
package k12a_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        REQ_WRITE = 2'd0,
        REQ_TEST  = 2'd1,
        REQ_SHIFT = 2'd2,
        REQ_RSVD  = 2'd3
    } alu_req_kind_t;

    typedef enum logic {
        ALU_OPERAND_SEL_B    = 1'b0,
        ALU_OPERAND_SEL_INST = 1'b1
    } alu_operand_sel_t;

    localparam logic [2:0] ALU_FUNC_SUB = 3'h5;
    localparam logic [2:0] ALU_FUNC_SAR = 3'h6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUS_WAIT = 3'd1,
        ST_EXEC     = 3'd2,
        ST_EVAL     = 3'd3,
        ST_RESP     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/k12a_alu_sequencer.sv
// Sequences the shared 8-bit ALU for the decode stage: bus arbitration,
// single-pass writes, condition tests and multi-pass arithmetic shifts.
//
// state    | meaning
// IDLE     | ready for a request
// BUS_WAIT | requesting the data bus, waiting for grant
// EXEC     | ALU drives bus, register A loads (one cycle per pass)
// EVAL     | condition test, alu_condition captured on exit
// RESP     | one-cycle completion pulse
module k12a_alu_sequencer
    import k12a_alu_sequencer_pkg::*;
#(
    parameter int MAX_SHIFT = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_kind,
    input  logic [15:0]      req_inst,
    input  logic             req_use_b,
    input  logic [2:0]       req_count,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic             alu_load_n,
    output alu_operand_sel_t alu_operand_sel,
    output logic             alu_subtract,
    output logic [15:0]      alu_inst,
    input  logic             alu_condition,
    output logic             a_load_n,
    output logic             resp_valid,
    output logic             resp_cond,
    output logic             busy
);

    localparam int CNT_W = $clog2(MAX_SHIFT + 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_operand_sel_t sel_q, sel_d;
    logic             sub_q, sub_d;
    logic [15:0]      inst_q, inst_d;
    logic             cond_q, cond_d;
    logic             bus_req_q, bus_req_d;
    logic             alu_load_n_q, alu_load_n_d;
    logic             a_load_n_q, a_load_n_d;
    logic             resp_valid_q, resp_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        sub_d   = sub_q;
        inst_d  = inst_q;
        cond_d  = cond_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cond_d = 1'b0;
                    case (alu_req_kind_t'(req_kind))
                        REQ_WRITE: begin
                            state_d = ST_BUS_WAIT;
                            cnt_d   = CNT_W'(1);
                            sel_d   = req_use_b ? ALU_OPERAND_SEL_B : ALU_OPERAND_SEL_INST;
                            inst_d  = req_inst;
                            sub_d   = (req_inst[10:8] == ALU_FUNC_SUB);
                        end
                        REQ_TEST: begin
                            state_d = ST_EVAL;
                            sel_d   = req_use_b ? ALU_OPERAND_SEL_B : ALU_OPERAND_SEL_INST;
                            inst_d  = req_inst;
                            sub_d   = 1'b1;
                        end
                        REQ_SHIFT: begin
                            state_d = (req_count != 3'd0) ? ST_BUS_WAIT : ST_RESP;
                            cnt_d   = CNT_W'(req_count);
                            sel_d   = req_use_b ? ALU_OPERAND_SEL_B : ALU_OPERAND_SEL_INST;
                            inst_d  = {req_inst[15:11], ALU_FUNC_SAR, req_inst[7:0]};
                            sub_d   = 1'b0;
                        end
                        default: state_d = ST_RESP;
                    endcase
                end
            end
            ST_BUS_WAIT: begin
                if (bus_gnt) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // <= rather than == so a corrupted zero count cannot lock the bus
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EVAL: begin
                cond_d  = alu_condition;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                cond_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they come straight off flops.
        bus_req_d    = (state_d == ST_BUS_WAIT) || (state_d == ST_EXEC);
        alu_load_n_d = (state_d != ST_EXEC);
        a_load_n_d   = (state_d != ST_EXEC);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sel_q        <= ALU_OPERAND_SEL_B;
            sub_q        <= 1'b0;
            inst_q       <= '0;
            cond_q       <= 1'b0;
            bus_req_q    <= 1'b0;
            alu_load_n_q <= 1'b1;
            a_load_n_q   <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            sub_q        <= sub_d;
            inst_q       <= inst_d;
            cond_q       <= cond_d;
            bus_req_q    <= bus_req_d;
            alu_load_n_q <= alu_load_n_d;
            a_load_n_q   <= a_load_n_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready       = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign bus_req         = bus_req_q;
    assign alu_load_n      = alu_load_n_q;
    assign a_load_n        = a_load_n_q;
    assign resp_valid      = resp_valid_q;
    assign resp_cond       = cond_q;
    assign alu_operand_sel = sel_q;
    assign alu_subtract    = sub_q;
    assign alu_inst        = inst_q;

endmodule

// File: tb/tb_k12a_alu_sequencer.sv
// Directed bench for k12a_alu_sequencer: one task per scenario, expected
// values worked out by hand from the request/latency rules.
module tb_k12a_alu_sequencer;
    import k12a_alu_sequencer_pkg::*;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_kind;
    logic [15:0]      req_inst;
    logic             req_use_b;
    logic [2:0]       req_count;
    logic             bus_req;
    logic             bus_gnt;
    logic             alu_load_n;
    alu_operand_sel_t alu_operand_sel;
    logic             alu_subtract;
    logic [15:0]      alu_inst;
    logic             alu_condition;
    logic             a_load_n;
    logic             resp_valid;
    logic             resp_cond;
    logic             busy;

    int checks = 0;
    int errors = 0;

    int obs_load, obs_aload, obs_aload_run, obs_bus, obs_bus_nogrant;
    int obs_resp, obs_resp_cyc;
    logic obs_resp_cond;

    k12a_alu_sequencer #(.MAX_SHIFT(7)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_inst(req_inst), .req_use_b(req_use_b), .req_count(req_count),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .alu_load_n(alu_load_n),
        .alu_operand_sel(alu_operand_sel), .alu_subtract(alu_subtract),
        .alu_inst(alu_inst), .alu_condition(alu_condition), .a_load_n(a_load_n),
        .resp_valid(resp_valid), .resp_cond(resp_cond), .busy(busy)
    );

    always #5 clock = ~clock;

    // Grant must stay high while the ALU drives the bus.
    always @(posedge clock) begin
        if (reset_n && !alu_load_n && !bus_gnt) begin
            errors++;
            $display("FAIL gnt_in_exec: bus_gnt=%0b while alu_load_n low, required 1", bus_gnt);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [1:0] kind, input logic [15:0] inst,
                        input logic use_b, input logic [2:0] cnt);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: req_ready=%0b before accept, required 1", req_ready);
        end
        req_kind  = kind;
        req_inst  = inst;
        req_use_b = use_b;
        req_count = cnt;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic observe(input int ncyc, input int gnt_cyc);
        int run;
        run = 0;
        obs_load = 0; obs_aload = 0; obs_aload_run = 0; obs_bus = 0;
        obs_bus_nogrant = 0; obs_resp = 0; obs_resp_cyc = -1; obs_resp_cond = 1'bx;
        for (int c = 0; c < ncyc; c++) begin
            if (c == gnt_cyc) bus_gnt = 1'b1;
            if (!alu_load_n) obs_load++;
            if (!a_load_n) begin
                obs_aload++;
                run++;
                if (run > obs_aload_run) obs_aload_run = run;
            end else begin
                run = 0;
            end
            if (bus_req) obs_bus++;
            if (bus_req && !bus_gnt) obs_bus_nogrant++;
            if (resp_valid) begin
                obs_resp++;
                if (obs_resp_cyc < 0) begin
                    obs_resp_cyc  = c;
                    obs_resp_cond = resp_cond;
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({alu_load_n, a_load_n, bus_req, resp_valid, resp_cond, alu_subtract, busy, req_ready} !== 8'b1100_0001) begin
            errors++;
            $display("FAIL reset_ctrl: ld/ald/breq/rv/rc/sub/busy/rdy=%b, required 11000001",
                     {alu_load_n, a_load_n, bus_req, resp_valid, resp_cond, alu_subtract, busy, req_ready});
        end
        checks++;
        if (alu_inst !== 16'h0000 || alu_operand_sel !== ALU_OPERAND_SEL_B) begin
            errors++;
            $display("FAIL reset_alu: inst=%h sel=%0d, required 0000 sel=0", alu_inst, alu_operand_sel);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        bus_gnt = 1'b1;
        send(REQ_WRITE, 16'h0512, 1'b0, 3'd0);
        checks++;
        if (alu_subtract !== 1'b1 || alu_inst !== 16'h0512 || alu_operand_sel !== ALU_OPERAND_SEL_INST) begin
            errors++;
            $display("FAIL write_ctrl: sub=%0b inst=%h sel=%0d, required 1 0512 1", alu_subtract, alu_inst, alu_operand_sel);
        end
        observe(6, 0);
        checks++;
        if (obs_load != 1 || obs_aload != 1) begin
            errors++;
            $display("FAIL write_strobes: alu_load cycles=%0d a_load cycles=%0d, required 1 1", obs_load, obs_aload);
        end
        checks++;
        if (obs_resp_cyc != 2 || obs_resp != 1 || obs_resp_cond !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: resp at accept+%0d count=%0d cond=%0b, required +3 1 0",
                     obs_resp_cyc + 1, obs_resp, obs_resp_cond);
        end
    endtask

    task automatic test_test(input logic cond);
        send(REQ_TEST, 16'h0400, 1'b1, 3'd0);
        alu_condition = cond;
        checks++;
        if (alu_subtract !== 1'b1 || alu_operand_sel !== ALU_OPERAND_SEL_B || alu_inst !== 16'h0400) begin
            errors++;
            $display("FAIL test_ctrl: sub=%0b sel=%0d inst=%h, required 1 0 0400", alu_subtract, alu_operand_sel, alu_inst);
        end
        observe(5, 0);
        alu_condition = 1'b0;
        checks++;
        if (obs_bus != 0 || obs_load != 0 || obs_resp_cyc != 1 || obs_resp != 1 || obs_resp_cond !== cond) begin
            errors++;
            $display("FAIL test_resp: bus=%0d load=%0d resp at +%0d count=%0d cond=%0b, required 0 0 +2 1 %0b",
                     obs_bus, obs_load, obs_resp_cyc + 1, obs_resp, obs_resp_cond, cond);
        end
    endtask

    task automatic test_shift_delay();
        bus_gnt = 1'b0;
        send(REQ_SHIFT, 16'h0533, 1'b1, 3'd3);
        checks++;
        if (alu_inst !== 16'h0633 || alu_subtract !== 1'b0 || alu_operand_sel !== ALU_OPERAND_SEL_B) begin
            errors++;
            $display("FAIL shift_ctrl: inst=%h sub=%0b sel=%0d, required 0633 0 0", alu_inst, alu_subtract, alu_operand_sel);
        end
        observe(12, 4);
        checks++;
        if (obs_bus_nogrant != 4 || obs_bus != 8) begin
            errors++;
            $display("FAIL shift_bus: req w/o grant=%0d total req=%0d, required 4 8", obs_bus_nogrant, obs_bus);
        end
        checks++;
        if (obs_aload != 3 || obs_aload_run != 3 || obs_load != 3) begin
            errors++;
            $display("FAIL shift_passes: a_load=%0d run=%0d alu_load=%0d, required 3 3 3", obs_aload, obs_aload_run, obs_load);
        end
        checks++;
        if (obs_resp_cyc != 8 || obs_resp != 1 || obs_resp_cond !== 1'b0) begin
            errors++;
            $display("FAIL shift_resp: resp at +%0d count=%0d cond=%0b, required +9 1 0", obs_resp_cyc + 1, obs_resp, obs_resp_cond);
        end
    endtask

    task automatic test_shift_zero();
        bus_gnt = 1'b1;
        send(REQ_SHIFT, 16'h0177, 1'b0, 3'd0);
        observe(4, 0);
        checks++;
        if (obs_bus != 0 || obs_load != 0 || obs_aload != 0 || obs_resp_cyc != 0 || obs_resp != 1) begin
            errors++;
            $display("FAIL shift0: bus=%0d load=%0d aload=%0d resp at +%0d count=%0d, required 0 0 0 +1 1",
                     obs_bus, obs_load, obs_aload, obs_resp_cyc + 1, obs_resp);
        end
        checks++;
        if (alu_inst !== 16'h0677) begin
            errors++;
            $display("FAIL shift0_inst: inst=%h, required 0677", alu_inst);
        end
    endtask

    task automatic test_reserved();
        alu_condition = 1'b1;
        send(REQ_RSVD, 16'hFFFF, 1'b1, 3'd7);
        observe(4, 0);
        alu_condition = 1'b0;
        checks++;
        if (obs_bus != 0 || obs_resp_cyc != 0 || obs_resp != 1 || obs_resp_cond !== 1'b0 || alu_inst !== 16'h0677) begin
            errors++;
            $display("FAIL reserved: bus=%0d resp at +%0d count=%0d cond=%0b inst=%h, required 0 +1 1 0 0677",
                     obs_bus, obs_resp_cyc + 1, obs_resp, obs_resp_cond, alu_inst);
        end
    endtask

    task automatic test_back_to_back();
        req_kind  = REQ_TEST;
        req_inst  = 16'h0300;
        req_use_b = 1'b0;
        req_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (req_ready !== (c % 3 == 0) || resp_valid !== (c % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ready=%0b resp_valid=%0b, required %0b %0b",
                         c, req_ready, resp_valid, (c % 3 == 0), (c % 3 == 2));
            end
            step();
        end
        req_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_shift();
        bus_gnt = 1'b1;
        send(REQ_SHIFT, 16'h0011, 1'b0, 3'd5);
        step(); step(); step();
        checks++;
        if (a_load_n !== 1'b0 || bus_req !== 1'b1) begin
            errors++;
            $display("FAIL midshift_pre: a_load_n=%0b bus_req=%0b, required 0 1", a_load_n, bus_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (alu_load_n !== 1'b1 || a_load_n !== 1'b1 || bus_req !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midshift_async: ld=%0b ald=%0b breq=%0b rv=%0b busy=%0b, required 1 1 0 0 0",
                     alu_load_n, a_load_n, bus_req, resp_valid, busy);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        observe(6, 0);
        checks++;
        if (obs_resp != 0 || obs_bus != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midshift_after: resp=%0d bus=%0d ready=%0b, required 0 0 1", obs_resp, obs_bus, req_ready);
        end
    endtask

    initial begin
        req_valid     = 1'b0;
        req_kind      = 2'd0;
        req_inst      = 16'h0000;
        req_use_b     = 1'b0;
        req_count     = 3'd0;
        bus_gnt       = 1'b1;
        alu_condition = 1'b0;
        test_reset();
        test_write();
        test_test(1'b1);
        test_test(1'b0);
        test_shift_delay();
        test_shift_zero();
        test_reserved();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
